// File: rtl/lock_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lock_sequencer_if                                                        |
// | Sensor inputs and valve/gate commands of the canal lock sequencer.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface lock_sequencer_if #(
  parameter int LEVEL_W = 6
);
  logic               arriving_upper;
  logic               arriving_lower;
  logic               boat_in;
  logic               boat_out;
  logic [LEVEL_W-1:0] water_level;
  logic               fill_valve;
  logic               drain_valve;
  logic               upper_gate_open;
  logic               lower_gate_open;
  logic               gate_moving;
  logic               occupied;
  logic               pend_upper;
  logic               pend_lower;

  modport master (
    output arriving_upper, arriving_lower, boat_in, boat_out, water_level,
    input  fill_valve, drain_valve, upper_gate_open, lower_gate_open,
           gate_moving, occupied, pend_upper, pend_lower
  );

  modport slave (
    input  arriving_upper, arriving_lower, boat_in, boat_out, water_level,
    output fill_valve, drain_valve, upper_gate_open, lower_gate_open,
           gate_moving, occupied, pend_upper, pend_lower
  );
endinterface
`default_nettype wire

// File: rtl/lock_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lock_sequencer                                                           |
// | Canal lock control: request arbitration, level adjust, gate sequencing.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lock_sequencer #(
  parameter int LEVEL_W       = 6,
  parameter int UPPER_LEVEL   = 50,
  parameter int LOWER_LEVEL   = 10,
  parameter int GATE_CYCLES   = 8,
  parameter int ENTRY_TIMEOUT = 200
) (
  input  wire logic         clk,
  input  wire logic         reset,
  lock_sequencer_if.slave   bus
);
  localparam int c_CNT_MAX = (GATE_CYCLES > ENTRY_TIMEOUT) ? GATE_CYCLES : ENTRY_TIMEOUT;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_SAT    = c_CNT_W'(c_CNT_MAX);
  localparam logic [c_CNT_W-1:0] c_GATE_LAST  = c_CNT_W'(GATE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_ENTRY_LAST = c_CNT_W'(ENTRY_TIMEOUT - 1);
  localparam logic [LEVEL_W-1:0] c_UPPER      = LEVEL_W'(UPPER_LEVEL);
  localparam logic [LEVEL_W-1:0] c_LOWER      = LEVEL_W'(LOWER_LEVEL);

  typedef enum logic [3:0] {
    S_IDLE, S_ADJ_IN, S_OPEN_IN, S_WAIT_IN, S_CLOSE_IN,
    S_ADJ_OUT, S_OPEN_OUT, S_WAIT_OUT, S_CLOSE_OUT
  } state_t;

  state_t             r_state;
  logic               r_side;        // 1 = trip enters from the upper approach
  logic               r_last_upper;
  logic               r_abort;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_fill, r_drain, r_up_open, r_lo_open, r_moving, r_occupied;
  logic               r_pend_up, r_pend_lo;

  logic               w_at_up, w_at_lo, w_in_match, w_out_match;
  logic [c_CNT_W-1:0] w_cnt_inc;

  assign w_at_up     = (bus.water_level >= c_UPPER);
  assign w_at_lo     = (bus.water_level <= c_LOWER);
  assign w_in_match  = r_side ? w_at_up : w_at_lo;
  assign w_out_match = r_side ? w_at_lo : w_at_up;
  assign w_cnt_inc   = (r_cnt == c_CNT_SAT) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_side       <= 1'b0;
      r_last_upper <= 1'b0;
      r_abort      <= 1'b0;
      r_cnt        <= '0;
      r_fill       <= 1'b0;
      r_drain      <= 1'b0;
      r_up_open    <= 1'b0;
      r_lo_open    <= 1'b0;
      r_moving     <= 1'b0;
      r_occupied   <= 1'b0;
      r_pend_up    <= 1'b0;
      r_pend_lo    <= 1'b0;
    end else begin
      // Latch first; clears inside the FSM below take precedence.
      if (bus.arriving_upper) r_pend_up <= 1'b1;
      if (bus.arriving_lower) r_pend_lo <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_pend_up || r_pend_lo) begin
            r_side  <= r_pend_up & (~r_pend_lo | ~r_last_upper);
            r_state <= S_ADJ_IN;
          end
        end
        S_ADJ_IN: begin
          if (w_in_match) begin
            r_fill   <= 1'b0;
            r_drain  <= 1'b0;
            r_moving <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_OPEN_IN;
          end else begin
            r_fill   <= r_side;
            r_drain  <= ~r_side;
          end
        end
        S_OPEN_IN: begin
          if (r_cnt == c_GATE_LAST) begin
            r_moving  <= 1'b0;
            r_up_open <= r_side;
            r_lo_open <= ~r_side;
            r_cnt     <= '0;
            r_state   <= S_WAIT_IN;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT_IN: begin
          if (bus.boat_in || r_cnt == c_ENTRY_LAST) begin
            if (r_side) r_pend_up <= 1'b0;
            else        r_pend_lo <= 1'b0;
            if (bus.boat_in) begin
              r_occupied   <= 1'b1;
              r_last_upper <= r_side;
            end
            r_abort   <= ~bus.boat_in;
            r_up_open <= 1'b0;
            r_lo_open <= 1'b0;
            r_moving  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_CLOSE_IN;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_CLOSE_IN: begin
          if (r_cnt == c_GATE_LAST) begin
            r_moving <= 1'b0;
            r_state  <= r_abort ? S_IDLE : S_ADJ_OUT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_ADJ_OUT: begin
          if (w_out_match) begin
            r_fill   <= 1'b0;
            r_drain  <= 1'b0;
            r_moving <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_OPEN_OUT;
          end else begin
            r_fill   <= ~r_side;
            r_drain  <= r_side;
          end
        end
        S_OPEN_OUT: begin
          if (r_cnt == c_GATE_LAST) begin
            r_moving  <= 1'b0;
            r_up_open <= ~r_side;
            r_lo_open <= r_side;
            r_cnt     <= '0;
            r_state   <= S_WAIT_OUT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WAIT_OUT: begin
          if (bus.boat_out) begin
            r_occupied <= 1'b0;
            r_up_open  <= 1'b0;
            r_lo_open  <= 1'b0;
            r_moving   <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_CLOSE_OUT;
          end
        end
        S_CLOSE_OUT: begin
          if (r_cnt == c_GATE_LAST) begin
            r_moving <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fill_valve      = r_fill;
  assign bus.drain_valve     = r_drain;
  assign bus.upper_gate_open = r_up_open;
  assign bus.lower_gate_open = r_lo_open;
  assign bus.gate_moving     = r_moving;
  assign bus.occupied        = r_occupied;
  assign bus.pend_upper      = r_pend_up;
  assign bus.pend_lower      = r_pend_lo;
endmodule
`default_nettype wire

// File: tb/tb_lock_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lock_sequencer                                                        |
// | Directed bench for lock_sequencer with hand-computed expectations.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lock_sequencer;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  lock_sequencer_if #(.LEVEL_W(6)) bus ();

  lock_sequencer #(
    .LEVEL_W(6), .UPPER_LEVEL(50), .LOWER_LEVEL(10),
    .GATE_CYCLES(8), .ENTRY_TIMEOUT(200)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {bus.fill_valve, bus.drain_valve, bus.upper_gate_open, bus.lower_gate_open,
            bus.gate_moving, bus.occupied, bus.pend_upper, bus.pend_lower};
  endfunction

  // Every clock also re-checks the safety interlocks.
  task automatic tick();
    @(posedge clk);
    #1;
    check("ilk_both_valves", 32'(bus.fill_valve & bus.drain_valve), 0);
    check("ilk_valve_gate", 32'((bus.fill_valve | bus.drain_valve) &
          (bus.upper_gate_open | bus.lower_gate_open | bus.gate_moving)), 0);
    check("ilk_two_gates", 32'(bus.upper_gate_open & bus.lower_gate_open), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.arriving_upper = 1'b0;
    bus.arriving_lower = 1'b0;
    bus.boat_in = 1'b0;
    bus.boat_out = 1'b0;
    tick();
    tick();
    check("reset_outs", 32'(outs()), 0);
    reset = 1'b0;
  endtask

  task automatic pulse_arrive(input bit up, input bit lo);
    bus.arriving_upper = up;
    bus.arriving_lower = lo;
    tick();
    bus.arriving_upper = 1'b0;
    bus.arriving_lower = 1'b0;
  endtask

  // Entered on the sample right after the FSM moved into an adjust state.
  task automatic do_adjust(input string tag, input bit ef, input bit ed, input logic [5:0] tgt);
    tick();
    if (ef || ed) begin
      check({tag, "_fill"}, 32'(bus.fill_valve), 32'(ef));
      check({tag, "_drain"}, 32'(bus.drain_valve), 32'(ed));
      tick();
      check({tag, "_valve_hold"}, 32'({bus.fill_valve, bus.drain_valve}), 32'({ef, ed}));
      bus.water_level = tgt;
      tick();
    end
    check({tag, "_valves_off"}, 32'({bus.fill_valve, bus.drain_valve}), 0);
    check({tag, "_moving"}, 32'(bus.gate_moving), 1);
  endtask

  task automatic gate_move(input string tag, input bit e_up, input bit e_lo);
    int n = 0;
    while (bus.gate_moving && n < 50) begin
      n++;
      tick();
    end
    check({tag, "_cycles"}, n, 8);
    check({tag, "_gates"}, 32'({bus.upper_gate_open, bus.lower_gate_open}), 32'({e_up, e_lo}));
  endtask

  task automatic trip(input string tag, input bit up, input bit in_valve, input bit out_valve,
                      input bit arrive_with_boat);
    do_adjust({tag, "_adj_in"}, up & in_valve, !up & in_valve, up ? 6'd50 : 6'd10);
    gate_move({tag, "_open_in"}, up, !up);
    bus.boat_in = 1'b1;
    if (arrive_with_boat) begin
      bus.arriving_upper = up;
      bus.arriving_lower = !up;
    end
    tick();
    bus.boat_in = 1'b0;
    bus.arriving_upper = 1'b0;
    bus.arriving_lower = 1'b0;
    check({tag, "_occupied"}, 32'(bus.occupied), 1);
    check({tag, "_pend_side_clr"}, 32'(up ? bus.pend_upper : bus.pend_lower), 0);
    gate_move({tag, "_close_in"}, 0, 0);
    do_adjust({tag, "_adj_out"}, !up & out_valve, up & out_valve, up ? 6'd10 : 6'd50);
    gate_move({tag, "_open_out"}, !up, up);
    bus.boat_out = 1'b1;
    tick();
    bus.boat_out = 1'b0;
    check({tag, "_vacated"}, 32'(bus.occupied), 0);
    gate_move({tag, "_close_out"}, 0, 0);
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.water_level = 6'd30;

    // Full upper-to-lower trip; a same-side arrival coincident with boat_in is dropped.
    do_reset();
    bus.boat_in = 1'b1;
    bus.boat_out = 1'b1;
    tick();
    bus.boat_in = 1'b0;
    bus.boat_out = 1'b0;
    check("idle_boat_ignored", 32'(outs()), 0);
    pulse_arrive(1, 0);
    check("s1_pend", 32'({bus.pend_upper, bus.pend_lower}), 32'(2'b10));
    tick();
    trip("s1", 1, 1, 1, 1);
    tick();
    tick();
    check("s1_idle", 32'(outs()), 0);

    // Tie after reset: upper first, then lower with no adjustment.
    bus.water_level = 6'd30;
    do_reset();
    pulse_arrive(1, 1);
    check("s2_pend", 32'({bus.pend_upper, bus.pend_lower}), 32'(2'b11));
    tick();
    trip("s2_up", 1, 1, 1, 0);
    check("s2_lower_held", 32'({bus.pend_upper, bus.pend_lower}), 32'(2'b01));
    tick();
    trip("s2_lo", 0, 0, 1, 0);
    check("s2_done", 32'(outs()), 0);

    // Entry watchdog abort at the lower approach.
    bus.water_level = 6'd5;
    do_reset();
    pulse_arrive(0, 1);
    tick();
    do_adjust("s3_adj", 0, 0, 6'd5);
    gate_move("s3_open", 0, 1);
    n = 0;
    while (bus.lower_gate_open && n < 300) begin
      n++;
      tick();
    end
    check("s3_timeout_cycles", n, 200);
    check("s3_abort_flags", 32'({bus.occupied, bus.pend_lower, bus.gate_moving}), 32'(3'b001));
    gate_move("s3_close", 0, 0);
    tick();
    tick();
    tick();
    check("s3_no_exit", 32'(outs()), 0);

    // New request during ADJ_OUT, boat pulses ignored there, reset in OPEN_OUT.
    bus.water_level = 6'd30;
    do_reset();
    pulse_arrive(1, 0);
    tick();
    do_adjust("s4_adj_in", 1, 0, 6'd50);
    gate_move("s4_open_in", 1, 0);
    bus.boat_in = 1'b1;
    tick();
    bus.boat_in = 1'b0;
    gate_move("s4_close_in", 0, 0);
    tick();
    check("s4_drain", 32'(bus.drain_valve), 1);
    bus.arriving_upper = 1'b1;
    bus.boat_in = 1'b1;
    bus.boat_out = 1'b1;
    tick();
    bus.arriving_upper = 1'b0;
    bus.boat_in = 1'b0;
    bus.boat_out = 1'b0;
    check("s4_mid_adj", 32'(outs()), 32'(8'b0100_0110));
    bus.water_level = 6'd10;
    tick();
    check("s4_adj_done", 32'({bus.drain_valve, bus.gate_moving}), 32'(2'b01));
    gate_move("s4_open_out", 0, 1);
    bus.boat_out = 1'b1;
    tick();
    bus.boat_out = 1'b0;
    gate_move("s4_close_out", 0, 0);
    check("s4_pend_kept", 32'(bus.pend_upper), 1);
    tick();
    do_adjust("s4_next_in", 1, 0, 6'd50);
    gate_move("s4_next_open", 1, 0);
    bus.boat_in = 1'b1;
    tick();
    bus.boat_in = 1'b0;
    gate_move("s4_next_close", 0, 0);
    do_adjust("s4_next_out", 0, 1, 6'd10);
    tick();
    pulse_arrive(0, 1);
    check("s4_open_out_state", 32'(outs()), 32'(8'b0000_1101));
    reset = 1'b1;
    tick();
    check("s4_reset_mid", 32'(outs()), 0);
    reset = 1'b0;
    tick();
    check("s4_after_reset", 32'(outs()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Parametrised successor to the single-chamber canal lock control path.
- Latches boat requests from both approaches and arbitrates between them.
- Sequences water adjustment, entry gate, boat entry, exit-side adjustment, exit gate and boat exit.
- Drives valve and gate commands with level interlocks, gate-motion timing and an entry watchdog; sits under the lock top level, fed by the level sensor and boat sensors.

Parameters:
LEVEL_W, 6, width of water_level
UPPER_LEVEL, 50, level at or above which the chamber matches the upper approach
LOWER_LEVEL, 10, level at or below which the chamber matches the lower approach (must be < UPPER_LEVEL)
GATE_CYCLES, 8, clocks a gate takes to open or close
ENTRY_TIMEOUT, 200, clocks to wait for boat entry before aborting

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
arriving_upper  in  1  pulse: boat waiting at upper approach
arriving_lower  in  1  pulse: boat waiting at lower approach
boat_in  in  1  pulse: boat fully inside chamber
boat_out  in  1  pulse: boat fully cleared exit gate
water_level  in  LEVEL_W  chamber level, unsigned
fill_valve  out  1  open fill valve
drain_valve  out  1  open drain valve
upper_gate_open  out  1  upper gate fully open
lower_gate_open  out  1  lower gate fully open
gate_moving  out  1  a gate is in motion
occupied  out  1  boat inside chamber
pend_upper  out  1  upper request latched
pend_lower  out  1  lower request latched

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE; pending flags cleared; gate counter and watchdog cleared.
  - last_served = lower, so upper wins the first tie.
- Request latch: arriving_x sets pend_x the next cycle; pend_x stays set until that side's boat_in is accepted, or until watchdog abort. Repeat pulses while set are no-ops.
- Level flags (unsigned compare): at_up = water_level >= UPPER_LEVEL; at_lo = water_level <= LOWER_LEVEL.
- FSM (registered, one transition per clock):
  - IDLE: if any pending, select entry side S (if both pending, the side opposite last_served) -> ADJ_IN.
  - ADJ_IN: fill_valve while S=upper and !at_up; drain_valve while S=lower and !at_lo; when matched -> OPEN_IN with valves off that cycle.
  - OPEN_IN: gate_moving=1 for GATE_CYCLES clocks, then S gate_open=1 -> WAIT_IN.
  - WAIT_IN:
    - boat_in -> clear pend_S, occupied=1, last_served=S -> CLOSE_IN.
    - No boat_in for ENTRY_TIMEOUT clocks -> clear pend_S, occupied stays 0 -> CLOSE_IN with abort flag.
  - CLOSE_IN: S gate_open=0 immediately, gate_moving for GATE_CYCLES. Then abort -> IDLE; else -> ADJ_OUT.
  - ADJ_OUT: adjust toward the opposite side O, same rules as ADJ_IN -> OPEN_OUT.
  - OPEN_OUT: as OPEN_IN for gate O -> WAIT_OUT.
  - WAIT_OUT: no timeout; boat_out -> occupied=0 -> CLOSE_OUT.
  - CLOSE_OUT: O gate_open=0, gate_moving GATE_CYCLES -> IDLE.
- Interlocks (always hold):
  - fill_valve and drain_valve never both 1.
  - No valve while any gate is open or moving.
  - At most one gate open or moving.
  - A gate may only open while its level flag is true.
- Arbitration: requests arriving mid-cycle stay latched. After a trip exits at O, a pending O request skips adjustment (ADJ_IN exits in 1 cycle).
- boat_in is ignored outside WAIT_IN; boat_out is ignored outside WAIT_OUT.
- Simultaneous arriving_x and boat_in for side x in the same cycle: boat_in is accepted and arriving_x is dropped.
- Reset mid-operation returns every output to 0 on the next edge, regardless of state. The upper level is responsible for safe physical state.
- Counters are sized clog2 of max(GATE_CYCLES, ENTRY_TIMEOUT)+1 and saturate; they do not wrap.

Test Plan:
- Reset, then level=30, arriving_upper pulse -> fill_valve=1 until level=50. Then gate_moving 8 clks, upper_gate_open=1. After boat_in: occupied=1, gate closes 8 clks, drain until level=10, lower_gate_open=1. After boat_out: occupied=0, IDLE.
- arriving_upper and arriving_lower in the same cycle after reset -> upper served first; pend_lower held; lower served next with no valve activity, since level is already 10.
- Level=5, arriving_lower, no boat_in for 200 clks -> lower gate closes, pend_lower=0, occupied=0, IDLE, no exit sequence.
- Upper trip mid-ADJ_OUT, arriving_upper pulse -> pend_upper=1; served after CLOSE_OUT with fill to 50.
- boat_in/boat_out pulses in IDLE and ADJ states -> no state or occupied change.
- Assert reset during OPEN_OUT -> next edge: all outputs 0, pend flags 0.
